// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack data bus, stalls upstream
// while a transfer is outstanding and loads the MEM/WB register (mem_out/inst/pc).
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] exe_out,
    input  logic [31:0] exe_inst,
    input  logic [31:0] exe_pc,
    input  logic        exe_valid,
    input  logic [31:0] exe_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [31:0] mem_out,
    output logic [31:0] mem_inst,
    output logic [31:0] mem_pc,
    output logic        mem_valid,
    output logic        addr_err,
    output logic        bus_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 32'd2);

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SB  = 6'h28;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: is_mem_op = 1'b1;
            default:                            is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        is_store_op = (op == OP_SW) || (op == OP_SB);
    endfunction

    // Big-endian lanes: offset 0 lives in bits 31:24.
    function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] lane);
        if (op == OP_SB) begin
            case (lane)
                2'd0:    lane_be = 4'b1000;
                2'd1:    lane_be = 4'b0100;
                2'd2:    lane_be = 4'b0010;
                default: lane_be = 4'b0001;
            endcase
        end else begin
            lane_be = 4'hF;
        end
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [31:0] data);
        case (op)
            OP_SB:   lane_wdata = {4{data[7:0]}};
            OP_SW:   lane_wdata = data;
            default: lane_wdata = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] load_result(input logic [5:0] op, input logic [1:0] lane,
                                                input logic [31:0] rdata);
        logic [7:0] sel;
        case (lane)
            2'd0:    sel = rdata[31:24];
            2'd1:    sel = rdata[23:16];
            2'd2:    sel = rdata[15:8];
            default: sel = rdata[7:0];
        endcase
        case (op)
            OP_LB:   load_result = {{24{sel[7]}}, sel};
            OP_LBU:  load_result = {24'h00_0000, sel};
            default: load_result = rdata;
        endcase
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [31:0]     hold_inst_r, hold_pc_r, hold_out_r, hold_data_r;
    logic [31:0]     mem_out_r, mem_inst_r, mem_pc_r;
    logic            mem_valid_r, addr_err_r, bus_err_r, bus_err_s;
    logic [5:0]      op_s, src_op_s, hold_op_s;
    logic [31:0]     src_out_s, src_data_s;
    logic            aligned_s, launch_s, misalign_s, in_wait_s;
    logic            timeout_hit_s, ack_s, bus_on_s;

    assign op_s          = exe_inst[31:26];
    assign hold_op_s     = hold_inst_r[31:26];
    assign aligned_s     = ~((op_s == OP_LW) || (op_s == OP_SW)) || (exe_out[1:0] == 2'b00);
    assign launch_s      = ~rst && (state_r == ST_IDLE) && exe_valid && is_mem_op(op_s) && aligned_s;
    assign misalign_s    = ~rst && (state_r == ST_IDLE) && exe_valid && is_mem_op(op_s) && ~aligned_s;
    assign in_wait_s     = ~rst && (state_r == ST_WAIT);
    // bus_err_r is raised exactly in the cycle the counter reaches TIMEOUT.
    assign timeout_hit_s = in_wait_s && bus_err_r;
    assign ack_s         = in_wait_s && dmem_ack && ~timeout_hit_s;
    assign bus_on_s      = launch_s || (in_wait_s && ~timeout_hit_s);
    assign stall         = launch_s || (in_wait_s && ~dmem_ack && ~timeout_hit_s);

    // Bus fields come from the live EXE/MEM inputs in IDLE and from the captured copy in WAIT.
    always_comb begin
        src_op_s   = op_s;
        src_out_s  = exe_out;
        src_data_s = exe_store_data;
        if (state_r == ST_WAIT) begin
            src_op_s   = hold_op_s;
            src_out_s  = hold_out_r;
            src_data_s = hold_data_r;
        end else begin
            src_op_s   = op_s;
            src_out_s  = exe_out;
            src_data_s = exe_store_data;
        end
    end

    // Bus outputs are forced to zero whenever no request is active.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0000_0000;
        dmem_be    = 4'h0;
        dmem_wdata = 32'h0000_0000;
        if (bus_on_s) begin
            dmem_req   = 1'b1;
            dmem_we    = is_store_op(src_op_s);
            dmem_addr  = {src_out_s[31:2], 2'b00};
            dmem_be    = lane_be(src_op_s, src_out_s[1:0]);
            dmem_wdata = lane_wdata(src_op_s, src_data_s);
        end else begin
            dmem_req   = 1'b0;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_s = ST_WAIT;
                    cnt_s   = CW'(1);
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            end
            ST_WAIT: begin
                if (timeout_hit_s || ack_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_WAIT;
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
        bus_err_s = (TIMEOUT != 32'd0) && (state_s == ST_WAIT) && (cnt_s == CW'(TIMEOUT));
    end

    // FSM state, wait counter and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bus_err_r  <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bus_err_r  <= bus_err_s;
            addr_err_r <= misalign_s;
        end
    end

    // Snapshot of the launching instruction, used for the bus and for retirement.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_inst_r <= 32'h0000_0000;
            hold_pc_r   <= 32'h0000_0000;
            hold_out_r  <= 32'h0000_0000;
            hold_data_r <= 32'h0000_0000;
        end else if (launch_s) begin
            hold_inst_r <= exe_inst;
            hold_pc_r   <= exe_pc;
            hold_out_r  <= exe_out;
            hold_data_r <= exe_store_data;
        end
    end

    // MEM/WB register; a bubble is presented to WB while a transfer is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_r <= 1'b0;
            mem_inst_r  <= 32'h0000_0000;
            mem_out_r   <= 32'h0000_0000;
            mem_pc_r    <= 32'h0000_0000;
        end else if (state_r == ST_IDLE) begin
            if (launch_s) begin
                mem_valid_r <= 1'b0;
                mem_inst_r  <= 32'h0000_0000;
            end else begin
                mem_valid_r <= exe_valid && ~misalign_s;
                mem_inst_r  <= (exe_valid && ~misalign_s) ? exe_inst : 32'h0000_0000;
                mem_out_r   <= exe_out;
                mem_pc_r    <= exe_pc;
            end
        end else if (ack_s) begin
            mem_valid_r <= 1'b1;
            mem_inst_r  <= hold_inst_r;
            mem_pc_r    <= hold_pc_r;
            mem_out_r   <= is_store_op(hold_op_s) ? hold_out_r
                                                  : load_result(hold_op_s, hold_out_r[1:0], dmem_rdata);
        end else if (timeout_hit_s) begin
            mem_valid_r <= 1'b0;
            mem_inst_r  <= 32'h0000_0000;
            mem_out_r   <= hold_out_r;
            mem_pc_r    <= hold_pc_r;
        end else begin
            mem_valid_r <= 1'b0;
            mem_inst_r  <= 32'h0000_0000;
        end
    end

    assign mem_valid = mem_valid_r;
    assign mem_inst  = mem_inst_r;
    assign mem_out   = mem_out_r;
    assign mem_pc    = mem_pc_r;
    assign addr_err  = addr_err_r;
    assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: an instruction-level model predicts every
// cycle's outputs, and a negedge process compares them against the DUT.
module tb_mem_access_stage;

    localparam int unsigned TO = 4;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SB  = 6'h28;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] exe_out, exe_inst, exe_pc, exe_store_data, dmem_rdata;
    logic        exe_valid, dmem_ack;
    logic        dmem_req, dmem_we, stall, mem_valid, addr_err, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, mem_out, mem_inst, mem_pc;
    logic [3:0]  dmem_be;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .exe_out(exe_out), .exe_inst(exe_inst), .exe_pc(exe_pc),
        .exe_valid(exe_valid), .exe_store_data(exe_store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall),
        .mem_out(mem_out), .mem_inst(mem_inst), .mem_pc(mem_pc),
        .mem_valid(mem_valid), .addr_err(addr_err), .bus_err(bus_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Expected combinational outputs for the current cycle.
    logic        e_req, e_we, e_stall;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    // Expected registered outputs now (m_) and after the next edge (n_).
    logic        m_valid, m_aerr, m_berr, n_valid, n_aerr, n_berr;
    logic [31:0] m_inst, m_out, m_pc, n_inst, n_out, n_pc;
    bit          chk_on = 1'b0;
    logic [31:0] pc;
    bit          pin_bus = 1'b0;
    logic [31:0] pin_addr, pin_wdata;
    logic [3:0]  pin_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("dmem_req",   32'(dmem_req),   32'(e_req));
            chk("dmem_we",    32'(dmem_we),    32'(e_we));
            chk("dmem_addr",  dmem_addr,       e_addr);
            chk("dmem_be",    32'(dmem_be),    32'(e_be));
            chk("dmem_wdata", dmem_wdata,      e_wdata);
            chk("stall",      32'(stall),      32'(e_stall));
            chk("mem_valid",  32'(mem_valid),  32'(m_valid));
            chk("mem_inst",   mem_inst,        m_inst);
            chk("mem_out",    mem_out,         m_out);
            chk("mem_pc",     mem_pc,          m_pc);
            chk("addr_err",   32'(addr_err),   32'(m_aerr));
            chk("bus_err",    32'(bus_err),    32'(m_berr));
        end
    end

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        m_valid = n_valid; m_inst = n_inst; m_out = n_out; m_pc = n_pc;
        m_aerr  = n_aerr;  m_berr = n_berr;
        #1;
    endtask

    task automatic bus_idle_exp();
        e_req = 1'b0; e_we = 1'b0; e_addr = 32'h0; e_be = 4'h0; e_wdata = 32'h0; e_stall = 1'b0;
    endtask

    task automatic hold_next();
        n_valid = 1'b0; n_inst = 32'h0; n_out = m_out; n_pc = m_pc; n_aerr = 1'b0; n_berr = 1'b0;
    endtask

    task automatic run_inst(input bit valid, input logic [31:0] inst, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] rdata,
                            input int unsigned delay, input bit nack);
        logic [5:0]  op;
        logic [1:0]  lane;
        logic [7:0]  b;
        logic [31:0] result;
        bit          is_mem, is_store, mis;
        int unsigned limit;
        op       = inst[31:26];
        lane     = addr[1:0];
        is_mem   = op inside {OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB};
        is_store = (op == OP_SW) || (op == OP_SB);
        mis      = valid && is_mem && ((op == OP_LW) || (op == OP_SW)) && (lane != 2'd0);
        exe_valid = valid; exe_inst = inst; exe_out = addr; exe_pc = pc;
        exe_store_data = sdata; dmem_rdata = $urandom;
        if (!valid || !is_mem || mis) begin
            dmem_ack = 1'($urandom_range(0, 1));
            bus_idle_exp();
            n_valid = valid && !mis; n_inst = n_valid ? inst : 32'h0;
            n_out = addr; n_pc = pc; n_aerr = mis; n_berr = 1'b0;
            step();
        end else begin
            dmem_ack = 1'b0;
            e_req   = 1'b1;
            e_we    = is_store;
            e_addr  = addr & 32'hFFFF_FFFC;
            e_be    = (op == OP_SB) ? (4'b1000 >> lane) : 4'hF;
            e_wdata = (op == OP_SB) ? ({24'h0, sdata[7:0]} * 32'h0101_0101)
                    : (op == OP_SW) ? sdata : 32'h0;
            b = 8'(rdata >> (8 * (3 - int'(lane))));
            case (op)
                OP_LB:   result = 32'($signed(b));
                OP_LBU:  result = {24'h0, b};
                OP_LW:   result = rdata;
                default: result = addr;
            endcase
            limit = nack ? TO : delay;
            if (pin_bus) begin
                #1;
                chk("pin_addr",  dmem_addr,       pin_addr);
                chk("pin_be",    32'(dmem_be),    32'(pin_be));
                chk("pin_wdata", dmem_wdata,      pin_wdata);
            end
            for (int c = 0; c <= int'(limit); c++) begin
                hold_next();
                if (c == int'(limit)) begin
                    e_stall = 1'b0;
                    if (nack) begin
                        e_req = 1'b0; e_we = 1'b0; e_addr = 32'h0; e_be = 4'h0; e_wdata = 32'h0;
                        n_out = addr; n_pc = pc;
                    end else begin
                        dmem_ack = 1'b1; dmem_rdata = rdata;
                        n_valid = 1'b1; n_inst = inst; n_out = result; n_pc = pc;
                    end
                end else begin
                    e_stall = 1'b1;
                    n_berr  = nack && (c == int'(limit) - 1);
                end
                step();
                dmem_ack = 1'b0; dmem_rdata = $urandom;
            end
        end
        pc = pc + 32'd4;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        int unsigned sel;
        rst = 1'b1; exe_valid = 1'b0; exe_inst = 32'h0; exe_out = 32'h0; exe_pc = 32'h0;
        exe_store_data = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0; pc = 32'h0000_1000;
        @(posedge clk); #1;
        m_valid = 1'b0; m_inst = 32'h0; m_out = 32'h0; m_pc = 32'h0; m_aerr = 1'b0; m_berr = 1'b0;
        n_valid = 1'b0; n_inst = 32'h0; n_out = 32'h0; n_pc = 32'h0; n_aerr = 1'b0; n_berr = 1'b0;
        bus_idle_exp();
        chk_on = 1'b1;
        step();
        rst = 1'b0;

        // ADD pass-through
        run_inst(1'b1, {6'h00, 26'h000_0020}, 32'h0000_1234, 32'h0, 32'h0, 1, 1'b0);
        chk("lit_add_out", mem_out, 32'h0000_1234);
        chk("lit_add_valid", 32'(mem_valid), 32'd1);

        // LB / LBU at 0x103, ack after 3 cycles
        pin_bus = 1'b1; pin_addr = 32'h0000_0100; pin_be = 4'hF; pin_wdata = 32'h0;
        run_inst(1'b1, {OP_LB, 26'h1}, 32'h0000_0103, 32'h0, 32'h1122_33F0, 3, 1'b0);
        chk("lit_lb", mem_out, 32'hFFFF_FFF0);
        run_inst(1'b1, {OP_LBU, 26'h2}, 32'h0000_0103, 32'h0, 32'h1122_33F0, 3, 1'b0);
        chk("lit_lbu", mem_out, 32'h0000_00F0);

        // SB 0xAB at 0x201
        pin_addr = 32'h0000_0200; pin_be = 4'b0100; pin_wdata = 32'hABAB_ABAB;
        run_inst(1'b1, {OP_SB, 26'h3}, 32'h0000_0201, 32'h0000_00AB, 32'h0, 2, 1'b0);
        pin_bus = 1'b0;
        chk("lit_sb_out", mem_out, 32'h0000_0201);

        // Misaligned LW
        run_inst(1'b1, {OP_LW, 26'h4}, 32'h0000_0102, 32'h0, 32'h0, 1, 1'b0);
        chk("lit_mis_aerr", 32'(addr_err), 32'd1);
        chk("lit_mis_valid", 32'(mem_valid), 32'd0);

        // LW with no ack: timeout
        run_inst(1'b1, {OP_LW, 26'h5}, 32'h0000_0400, 32'h0, 32'h0, 1, 1'b1);
        chk("lit_to_valid", 32'(mem_valid), 32'd0);
        chk("lit_to_inst", mem_inst, 32'h0);

        // Reset while a LW is pending, then a late ack
        exe_valid = 1'b1; exe_inst = {OP_LW, 26'h6}; exe_out = 32'h0000_0300; exe_pc = pc;
        exe_store_data = 32'h0; dmem_ack = 1'b0;
        e_req = 1'b1; e_we = 1'b0; e_addr = 32'h0000_0300; e_be = 4'hF; e_wdata = 32'h0; e_stall = 1'b1;
        hold_next(); step();
        hold_next(); step();
        rst = 1'b1; bus_idle_exp();
        n_valid = 1'b0; n_inst = 32'h0; n_out = 32'h0; n_pc = 32'h0; n_aerr = 1'b0; n_berr = 1'b0;
        step();
        rst = 1'b0; exe_valid = 1'b0; exe_out = 32'h0000_0055; exe_pc = 32'h0000_0060; dmem_ack = 1'b1;
        n_valid = 1'b0; n_inst = 32'h0; n_out = 32'h0000_0055; n_pc = 32'h0000_0060;
        #1;
        chk("lit_rst_req", 32'(dmem_req), 32'd0);
        chk("lit_rst_stall", 32'(stall), 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("lit_rst_valid", 32'(mem_valid), 32'd0);
        chk("lit_rst_out", mem_out, 32'h0000_0055);
        pc = pc + 32'd4;

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0:       op = OP_LW;
                1:       op = OP_LB;
                2:       op = OP_LBU;
                3:       op = OP_SW;
                4:       op = OP_SB;
                5:       op = 6'h00;
                default: op = 6'($urandom);
            endcase
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_inst(sel != 7, {op, 26'($urandom)}, a, $urandom, $urandom,
                     $urandom_range(1, TO - 1), $urandom_range(0, 9) == 0);
        end

        run_inst(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1'b0);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage consumer of the EXE/MEM pipeline register: takes the latched ALU result, instruction and PC, and performs load/store traffic on a request/acknowledge data-memory bus. Non-memory instructions pass through in one cycle. Drives a stall back to the upstream stages while a bus transfer is outstanding, and captures results into the MEM/WB register (mem_out, mem_inst, mem_pc).

## Interface
- TIMEOUT, 255: max cycles waiting for dmem_ack before aborting; 0 disables the timeout.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- exe_out  in  32  ALU result; effective address for loads/stores
- exe_inst  in  32  instruction in the EXE/MEM register
- exe_pc  in  32  PC of that instruction
- exe_valid  in  1  1 = exe_* holds a real instruction; 0 = bubble
- exe_store_data  in  32  rt value for stores
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address ({exe_out[31:2],2'b00})
- dmem_wdata  out  32  write data, byte lanes replicated
- dmem_be  out  4  byte enables, be[3] = bits 31:24
- dmem_rdata  in  32  read data, valid when dmem_ack=1
- dmem_ack  in  1  transfer complete, one-cycle pulse
- stall  out  1  hold upstream pipeline registers (drives their we low)
- mem_out  out  32  load data or pass-through ALU result
- mem_inst  out  32  instruction forwarded to WB
- mem_pc  out  32  PC forwarded to WB
- mem_valid  out  1  MEM/WB register holds a real instruction
- addr_err  out  1  one-cycle pulse: misaligned access
- bus_err  out  1  one-cycle pulse: ack timeout

## Operation
- Opcode is exe_inst[31:26]. Supported: LW 0x23, LB 0x20, LBU 0x24, SW 0x2B, SB 0x28. All other opcodes are non-memory.
- Big-endian byte order: addr[1:0]=0 selects bits 31:24, 3 selects bits 7:0.
- LW/SW require exe_out[1:0]=0. Misaligned: no bus request; addr_err pulses; the instruction retires as a bubble (mem_valid=0, mem_inst=0).
- SB: dmem_be is a one-hot lane chosen by addr[1:0]; dmem_wdata = {4{exe_store_data[7:0]}}. SW: be=4'hF, wdata=exe_store_data. Loads: be=4'hF, we=0.
- LB sign-extends the selected byte; LBU zero-extends it; LW returns the full word. Stores write exe_out to mem_out.
- FSM:
  - IDLE: on exe_valid, memory opcode and aligned address, assert dmem_req and go to WAIT; otherwise load the MEM/WB register directly.
  - WAIT: hold req, we, addr, be and wdata stable. On dmem_ack, load the MEM/WB register and go to IDLE. When the wait counter reaches TIMEOUT (TIMEOUT≠0), drop req, pulse bus_err, retire as a bubble and go to IDLE.
- stall = (IDLE & exe_valid & mem-op & aligned) | (WAIT & ~dmem_ack & ~timeout_hit). Combinational.
- Bubbles (exe_valid=0) load mem_valid=0, mem_inst=0; mem_out and mem_pc still load exe_out and exe_pc.
- dmem_ack in IDLE is ignored.

## Timing
- Reset: state IDLE, wait counter 0. All outputs 0: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_*, stall, addr_err, bus_err. If asserted mid-transfer, req drops at the next edge and the transfer is abandoned.
- dmem_req is combinational from state/inputs in IDLE and registered-state-driven in WAIT, so it is high from the first cycle the memory op appears.
- Non-memory op: MEM/WB register loads at the next edge; 1-cycle latency, no stall.
- Memory op with ack k cycles after req rises (k≥1): stall high for k cycles. The MEM/WB register loads on the ack edge; upstream advances on that same edge.
- Zero-wait ack in the first request cycle is not supported; the bus must ack no earlier than the cycle after req rises.
- Timeout: with req first high in cycle 0, abort occurs on the edge ending cycle TIMEOUT; bus_err is high in that cycle and stall is low in it.
- addr_err and bus_err are registered one-cycle pulses, asserted the cycle after detection.

## Test plan
- Reset mid-WAIT (LW pending, rst=1 for 1 cycle) -> next cycle req=0, stall=0, mem_valid=0; a late ack is ignored.
- ADD (opcode 0, exe_out=0x1234) -> no req, stall=0, next cycle mem_out=0x1234, mem_valid=1.
- LB addr 0x103, ack after 3 cycles with rdata=0x112233F0 -> stall high 3 cycles, dmem_addr=0x100, mem_out=0xFFFFFFF0. LBU with the same stimulus -> mem_out=0x000000F0.
- SB addr 0x201, data 0xAB -> be=4'b0100, wdata=0xABABABAB, we=1 until ack.
- LW addr 0x102 -> no req, addr_err pulses, mem_valid=0.
- TIMEOUT=4, LW with no ack -> req high for exactly 4 cycles, bus_err pulses, stall falls, mem_valid=0.
